// File: rtl/predictor_ctrl.sv
// Branch predictor table sequencer: sweeps the table clear after reset, then shares its single
// access slot between fetch lookups and execute resolutions, tracking in-flight predictions.
module predictor_ctrl #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_index,
  output logic               lookup_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               resolve_ready,
  output logic [INDEX_W-1:0] pt_rd_index,
  input  logic               pt_rd_taken,
  output logic               pt_wr_en,
  output logic [INDEX_W-1:0] pt_wr_index,
  output logic               pt_wr_taken,
  output logic               pt_init_en,
  output logic               mispredict,
  output logic [CNT_W-1:0]   resolved_cnt,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic               init_done
);

  localparam int unsigned          PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]       FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [INDEX_W-1:0]   SWEEP_LAST = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q;
  logic [INDEX_W-1:0] sweep_q;
  logic [INDEX_W-1:0] fifo_idx_q [DEPTH];
  logic [DEPTH-1:0]   fifo_pred_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]   resolved_cnt_q, resolved_cnt_d;
  logic [CNT_W-1:0]   correct_cnt_q, correct_cnt_d;
  logic               pred_valid_q, pred_taken_q, mispredict_q;

  logic               run_active, fifo_full, fifo_empty;
  logic               lookup_fire, resolve_fire, mismatch;
  logic [INDEX_W-1:0] head_idx;
  logic               head_pred;

  // Everything is gated by reset so outputs read idle during the reset cycle itself.
  assign run_active   = (state_q == ST_RUN) && !reset;
  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);
  assign head_idx     = fifo_idx_q[rd_ptr_q];
  assign head_pred    = fifo_pred_q[rd_ptr_q];

  assign lookup_ready  = run_active && !fifo_full && !resolve_valid;
  assign resolve_ready = run_active && !fifo_empty;
  assign lookup_fire   = lookup_valid && lookup_ready;
  assign resolve_fire  = resolve_valid && resolve_ready;
  assign mismatch      = resolve_taken != head_pred;

  assign pt_rd_index  = lookup_index;
  assign pt_wr_en     = resolve_fire;
  assign pt_wr_index  = (state_q == ST_INIT) ? sweep_q : head_idx;
  assign pt_wr_taken  = resolve_taken;
  assign pt_init_en   = (state_q == ST_INIT) && !reset;
  assign init_done    = (state_q == ST_RUN);

  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_taken_q;
  assign mispredict   = mispredict_q;
  assign resolved_cnt = resolved_cnt_q;
  assign correct_cnt  = correct_cnt_q;

  always_comb begin
    count_d        = count_q;
    resolved_cnt_d = resolved_cnt_q;
    correct_cnt_d  = correct_cnt_q;
    if (resolve_fire) begin
      // A wrong prediction means every younger entry was fetched down the wrong path.
      count_d = mismatch ? '0 : count_q - 1'b1;
      if (resolved_cnt_q != CNT_MAX) resolved_cnt_d = resolved_cnt_q + 1'b1;
      if (!mismatch && (correct_cnt_q != CNT_MAX)) correct_cnt_d = correct_cnt_q + 1'b1;
    end else if (lookup_fire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (lookup_fire) begin
      fifo_idx_q[wr_ptr_q]  <= lookup_index;
      fifo_pred_q[wr_ptr_q] <= pt_rd_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_INIT;
      sweep_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      resolved_cnt_q <= '0;
      correct_cnt_q  <= '0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      count_q        <= count_d;
      resolved_cnt_q <= resolved_cnt_d;
      correct_cnt_q  <= correct_cnt_d;
      pred_valid_q   <= lookup_fire;
      mispredict_q   <= resolve_fire && mismatch;
      if (lookup_fire) begin
        pred_taken_q <= pt_rd_taken;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
      end
      if (resolve_fire) rd_ptr_q <= mismatch ? wr_ptr_q : rd_ptr_q + 1'b1;
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == SWEEP_LAST) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_predictor_ctrl.sv
// Scoreboard bench for predictor_ctrl: directed lookups/resolves push expected predictions,
// table writes and mispredict pulses; a negedge monitor pops and compares them.
module tb_predictor_ctrl;
  localparam int INDEX_W = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               lookup_valid = 1'b0;
  logic [INDEX_W-1:0] lookup_index = '0;
  logic               lookup_ready;
  logic               pred_valid, pred_taken;
  logic               resolve_valid = 1'b0;
  logic               resolve_taken = 1'b0;
  logic               resolve_ready;
  logic [INDEX_W-1:0] pt_rd_index;
  logic               pt_rd_taken = 1'b0;
  logic               pt_wr_en;
  logic [INDEX_W-1:0] pt_wr_index;
  logic               pt_wr_taken, pt_init_en, mispredict, init_done;
  logic [CNT_W-1:0]   resolved_cnt, correct_cnt;

  always #5 clk = ~clk;

  predictor_ctrl #(.INDEX_W(INDEX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .pt_rd_index(pt_rd_index), .pt_rd_taken(pt_rd_taken),
    .pt_wr_en(pt_wr_en), .pt_wr_index(pt_wr_index), .pt_wr_taken(pt_wr_taken),
    .pt_init_en(pt_init_en), .mispredict(mispredict),
    .resolved_cnt(resolved_cnt), .correct_cnt(correct_cnt), .init_done(init_done)
  );

  typedef struct { int cyc; int idx; int val; } exp_t;
  typedef struct { int idx; int pred; } ent_t;

  exp_t q_pred[$];
  exp_t q_wr[$];
  exp_t q_misp[$];
  ent_t mfifo[$];
  int tests = 0, failed = 0, cyc = 0;
  int m_resolved = 0, m_correct = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (pred_valid) begin
      if (q_pred.size() == 0) check("pred_unexpected", int'(pred_valid), 0);
      else begin
        e = q_pred.pop_front();
        check("pred_cycle", cyc, e.cyc);
        check("pred_taken", int'(pred_taken), e.val);
      end
    end
    if (pt_wr_en) begin
      if (q_wr.size() == 0) check("wr_unexpected", int'(pt_wr_en), 0);
      else begin
        e = q_wr.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_index", int'(pt_wr_index), e.idx);
        check("wr_taken", int'(pt_wr_taken), e.val);
      end
    end
    if (mispredict) begin
      if (q_misp.size() == 0) check("misp_unexpected", int'(mispredict), 0);
      else begin
        e = q_misp.pop_front();
        check("misp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int idx, input int rt);
    exp_t e;
    lookup_valid = 1'b1;
    lookup_index = INDEX_W'(idx);
    pt_rd_taken  = rt[0];
    #1;
    check("lookup_ready", int'(lookup_ready), 1);
    check("pt_rd_index", int'(pt_rd_index), idx);
    e.cyc = cyc + 1; e.idx = idx; e.val = rt;
    q_pred.push_back(e);
    mfifo.push_back('{idx: idx, pred: rt});
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic do_resolve(input int taken);
    exp_t e;
    ent_t h;
    resolve_valid = 1'b1;
    resolve_taken = taken[0];
    #1;
    check("resolve_ready", int'(resolve_ready), 1);
    check("lookup_ready_prio", int'(lookup_ready), 0);
    h = mfifo.pop_front();
    e.cyc = cyc; e.idx = h.idx; e.val = taken;
    q_wr.push_back(e);
    m_resolved++;
    if (taken == h.pred) m_correct++;
    else begin
      e.cyc = cyc + 1; e.idx = 0; e.val = 1;
      q_misp.push_back(e);
      mfifo.delete();
    end
    step();
    resolve_valid = 1'b0;
    check("resolved_cnt", int'(resolved_cnt), m_resolved);
    check("correct_cnt", int'(correct_cnt), m_correct);
  endtask

  task automatic check_reset_vals();
    check("rst_lookup_ready", int'(lookup_ready), 0);
    check("rst_resolve_ready", int'(resolve_ready), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_pred_taken", int'(pred_taken), 0);
    check("rst_pt_wr_en", int'(pt_wr_en), 0);
    check("rst_pt_init_en", int'(pt_init_en), 0);
    check("rst_mispredict", int'(mispredict), 0);
    check("rst_resolved_cnt", int'(resolved_cnt), 0);
    check("rst_correct_cnt", int'(correct_cnt), 0);
    check("rst_init_done", int'(init_done), 0);
  endtask

  // Called at the start of the first cycle with reset low.
  task automatic init_sweep();
    reset = 1'b0;
    for (int i = 0; i < (1 << INDEX_W); i++) begin
      #1;
      check("init_en", int'(pt_init_en), 1);
      check("init_index", int'(pt_wr_index), i);
      check("init_lookup_ready", int'(lookup_ready), 0);
      check("init_done_early", int'(init_done), 0);
      step();
    end
    check("init_done", int'(init_done), 1);
    check("init_en_off", int'(pt_init_en), 0);
    check("run_lookup_ready", int'(lookup_ready), 1);
    check("run_resolve_ready", int'(resolve_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    init_sweep();

    // Resolve with an empty FIFO is ignored.
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #1;
    check("empty_resolve_ready", int'(resolve_ready), 0);
    check("empty_wr_en", int'(pt_wr_en), 0);
    step();
    resolve_valid = 1'b0;
    check("empty_resolved_cnt", int'(resolved_cnt), 0);

    // Lookup latency, then a correct resolve.
    do_lookup(5, 1);
    check("occ1_resolve_ready", int'(resolve_ready), 1);
    do_resolve(1);
    do_lookup(3, 0);
    do_resolve(0);

    // Fill the FIFO; the fifth request is back-pressured.
    do_lookup(0, 1);
    do_lookup(1, 0);
    do_lookup(2, 1);
    do_lookup(3, 0);
    lookup_valid = 1'b1; lookup_index = 4'd4; pt_rd_taken = 1'b0;
    #1;
    check("full_lookup_ready", int'(lookup_ready), 0);
    step();
    do_resolve(1);           // lookup_valid still high: resolve has priority
    do_lookup(4, 0);         // accepted the cycle after the resolve
    do_resolve(0);
    do_resolve(1);
    do_resolve(0);
    do_resolve(0);
    check("drained_resolve_ready", int'(resolve_ready), 0);

    // Mispredict flush.
    do_lookup(1, 0);
    do_lookup(2, 0);
    do_lookup(3, 0);
    do_resolve(1);
    check("flush_resolve_ready", int'(resolve_ready), 0);
    do_lookup(6, 1);         // accepted in the flush cycle
    do_resolve(1);

    // Reset mid-RUN with two entries in flight.
    do_lookup(7, 0);
    do_lookup(8, 1);
    reset = 1'b1;
    step();
    mfifo.delete();
    m_resolved = 0;
    m_correct = 0;
    check_reset_vals();
    step();
    init_sweep();
    check("post_rst_resolved_cnt", int'(resolved_cnt), 0);
    check("post_rst_correct_cnt", int'(correct_cnt), 0);

    step();
    step();
    check("pred_queue_empty", q_pred.size(), 0);
    check("wr_queue_empty", q_wr.size(), 0);
    check("misp_queue_empty", q_misp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/predictor_ctrl.md
# predictor_ctrl

Sequencer and access controller for the branch predictor table (`predictor_top`). After reset it initialises every table entry. It then arbitrates the table's single access slot between fetch-side lookups and execute-side resolutions. It tracks in-flight predictions in a FIFO, squashes wrong-path entries on a mispredict, and keeps prediction-accuracy counters.

## Interface
- `INDEX_W`, 4: table index width; the table has 2^INDEX_W entries.
- `DEPTH`, 4: in-flight FIFO depth; a power of two, at least 2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `lookup_valid` in 1: fetch requests a prediction.
- `lookup_index` in INDEX_W: table index for the lookup.
- `lookup_ready` out 1: lookup is accepted this cycle.
- `pred_valid` out 1: registered prediction is available.
- `pred_taken` out 1: registered prediction value.
- `resolve_valid` in 1: execute resolves the oldest in-flight branch.
- `resolve_taken` in 1: actual branch outcome.
- `resolve_ready` out 1: resolution is accepted this cycle.
- `pt_rd_index` out INDEX_W: table read index.
- `pt_rd_taken` in 1: table read data; combinational, same cycle.
- `pt_wr_en` out 1: table update strobe.
- `pt_wr_index` out INDEX_W: table update index.
- `pt_wr_taken` out 1: outcome to train the table with.
- `pt_init_en` out 1: forces entry `pt_wr_index` to weakly-not-taken.
- `mispredict` out 1: one-cycle pulse, registered.
- `resolved_cnt` out CNT_W: number of resolutions.
- `correct_cnt` out CNT_W: number of correct predictions.
- `init_done` out 1: high while in RUN.

## Operation
- FSM has two states, INIT and RUN. `reset` forces INIT, clears the sweep counter to 0 and empties the FIFO.
- **INIT**
  - `pt_init_en`=1 and `pt_wr_index`=sweep every cycle; the sweep counter increments by 1 each cycle.
  - After the cycle with sweep = 2^INDEX_W−1, go to RUN. INIT therefore lasts exactly 2^INDEX_W cycles.
  - `lookup_ready`=0, `resolve_ready`=0, `pt_wr_en`=0.
- **RUN**
  - `resolve_ready` = FIFO not empty.
  - `lookup_ready` = FIFO not full AND NOT `resolve_valid`. Resolution has priority for the single table slot. This is a combinational path from `resolve_valid`.
  - `pt_rd_index` = `lookup_index` at all times.
- **Lookup fire** (`lookup_valid` && `lookup_ready`):
  - Push {`lookup_index`, `pt_rd_taken`} into the FIFO.
  - Next cycle: `pred_valid`=1 and `pred_taken` = the pushed prediction.
  - Otherwise `pred_valid`=0 next cycle.
- **Resolve fire** (`resolve_valid` && `resolve_ready`):
  - Combinationally: `pt_wr_en`=1, `pt_wr_index` = FIFO head index, `pt_wr_taken` = `resolve_taken`.
  - Pop the FIFO head.
  - `resolved_cnt` += 1; if `resolve_taken` == head prediction, `correct_cnt` += 1. Both counters saturate at 2^CNT_W−1.
  - On a mismatch, the whole FIFO is emptied, squashing the wrong-path younger entries, and `mispredict`=1 next cycle.
- `resolve_valid` while the FIFO is empty is ignored: no write, no counter change.
- Lookup and resolve never fire in the same cycle.

## Timing
- **Reset values:** `lookup_ready`=0, `resolve_ready`=0, `pred_valid`=0, `pred_taken`=0, `pt_wr_en`=0, `pt_init_en`=0, `mispredict`=0, `resolved_cnt`=0, `correct_cnt`=0, `init_done`=0.
  - `pt_init_en` goes to 1 on the first cycle after `reset` is released.
- **Lookup to prediction:** 1 cycle.
- **Resolve to table write:** 0 cycles, same cycle as the fire.
- **Resolve to `mispredict`:** 1 cycle.
- **Table write vs. lookup:** a lookup issued in the cycle after an update to the same index reads the updated entry; the table writes at the clock edge.
- **FIFO:** pointers wrap modulo DEPTH.
  - Full: `lookup_ready`=0.
  - Empty: `resolve_ready`=0.
  - Flush clears the occupancy to 0 in the cycle after the mispredicting resolve. A lookup in that cycle is accepted normally.
- **Reset mid-RUN:** returns to INIT next cycle. The FIFO and counters clear, and the full sweep repeats.

## Test plan
- **Init sweep.** Release reset.
  - `pt_init_en` is high for exactly 16 cycles with indices 0..15 in order.
  - `init_done` rises on cycle 17.
  - `lookup_ready` stays 0 throughout INIT.
- **Lookup latency.** In RUN, look up index 5 with `pt_rd_taken`=1.
  - Next cycle: `pred_valid`=1, `pred_taken`=1.
  - FIFO occupancy is 1.
- **Full/back-pressure.** Issue 4 lookups with no resolves.
  - `lookup_ready`=0 on the 5th request.
  - One resolve makes `lookup_ready` 1 again the following cycle.
- **Correct resolve.** Look up index 3, predicting 0, then resolve with `resolve_taken`=0.
  - `pt_wr_en`=1 with `pt_wr_index`=3 and `pt_wr_taken`=0.
  - `resolved_cnt`=1, `correct_cnt`=1, no `mispredict`.
- **Mispredict flush.** Make 3 lookups (indices 1, 2, 3, all predicting 0), then resolve the first with `resolve_taken`=1.
  - `pt_wr_index`=1.
  - `mispredict` pulses 1 cycle later.
  - `resolve_ready`=0 afterwards (FIFO empty).
  - `correct_cnt` is unchanged.
- **Priority and reset.**
  - `lookup_valid` and `resolve_valid` high together gives `lookup_ready`=0 and only the resolve fires.
  - Asserting `reset` in RUN with 2 entries in flight gives, after release, a repeat of the INIT sweep and both counters at 0.
